// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding several channel FIFOs into one UART TX
//
// Purpose: picks the next non-empty channel FIFO after the one last served,
// pops one word from it, and hands that word to the UART transmitter. It waits
// in LOAD for tx_busy and gives up after TIMEOUT cycles.
//
// Ports:
//   clk          primary clock, rising edge
//   reset_n      asynchronous reset, active low
//   fifo_empty   per-channel empty flag (1 = no data)
//   fifo_data    per-channel read data, channel k at [k*WIDTH +: WIDTH]
//   read_fifo_n  per-channel read strobe, active low, one cycle
//   tx_busy      UART TX shifting a word
//   ld_tx_data   load request to UART TX
//   tx_data      word presented to UART TX
//   tx_channel   channel currently granted
//   timeout_err  one-cycle pulse when LOAD gave up without tx_busy
module uart_tx_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 63
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         fifo_empty,
  input  logic [NUM_CH*WIDTH-1:0]   fifo_data,
  output logic [NUM_CH-1:0]         read_fifo_n,
  input  logic                      tx_busy,
  output logic                      ld_tx_data,
  output logic [WIDTH-1:0]          tx_data,
  output logic [$clog2(NUM_CH)-1:0] tx_channel,
  output logic                      timeout_err
);

  localparam int CW = $clog2(NUM_CH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT);
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, ARB, READ, WAIT, LOAD} state_t;

  state_t            state, state_d;
  logic [CW-1:0]     last_grant, last_d;
  logic [CW-1:0]     grant_d;
  logic [NUM_CH-1:0] rd_d;
  logic              ld_d;
  logic [WIDTH-1:0]  data_d;
  logic [TW-1:0]     cnt, cnt_d;
  logic              terr_d;

  logic [CW-1:0]     pick;
  logic              pick_valid;
  logic [CW-1:0]     idx_c;
  int                idx;

  logic [WIDTH-1:0]  ch_data [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_data[k] = fifo_data[k*WIDTH +: WIDTH];
  end

  // Round-robin search: first non-empty channel starting at last_grant+1,
  // wrapping; last_grant itself is checked last.
  always_comb begin
    pick       = last_grant;
    pick_valid = 1'b0;
    idx        = 0;
    idx_c      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx   = (int'(last_grant) + i) % NUM_CH;
      idx_c = CW'(idx);
      if (!pick_valid && !fifo_empty[idx_c]) begin
        pick       = idx_c;
        pick_valid = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state;
    grant_d = tx_channel;
    last_d  = last_grant;
    rd_d    = '1;
    ld_d    = 1'b0;
    data_d  = tx_data;
    cnt_d   = cnt;
    terr_d  = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_busy) state_d = ARB;
      end
      ARB: begin
        if (pick_valid) begin
          state_d = READ;
          grant_d = pick;
          rd_d    = ~(NUM_CH'(1) << pick);
        end
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        // The FIFO presents the popped word one cycle after the strobe.
        state_d = LOAD;
        data_d  = ch_data[tx_channel];
        ld_d    = 1'b1;
        cnt_d   = '0;
      end
      LOAD: begin
        if (tx_busy || cnt == TMAX) begin
          state_d = IDLE;
          last_d  = tx_channel;
          // A simultaneous tx_busy makes the exit a normal one.
          terr_d  = !tx_busy;
        end else begin
          ld_d  = 1'b1;
          cnt_d = cnt + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      read_fifo_n <= '1;
      ld_tx_data  <= 1'b0;
      tx_data     <= '0;
      tx_channel  <= '0;
      timeout_err <= 1'b0;
      cnt         <= '0;
      last_grant  <= LAST_CH;
    end else begin
      state       <= state_d;
      read_fifo_n <= rd_d;
      ld_tx_data  <= ld_d;
      tx_data     <= data_d;
      tx_channel  <= grant_d;
      timeout_err <= terr_d;
      cnt         <= cnt_d;
      last_grant  <= last_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  fifo_empty;
  logic [31:0] fifo_data;
  logic [3:0]  read_fifo_n;
  logic        tx_busy;
  logic        ld_tx_data;
  logic [7:0]  tx_data;
  logic [1:0]  tx_channel;
  logic        timeout_err;

  logic [7:0]  dval [4];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         ch;
    logic [7:0] data;
    int         ld_n;
    bit         terr;
  } exp_t;

  exp_t sb[$];

  assign fifo_data = {dval[3], dval[2], dval[1], dval[0]};

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_CH(4), .WIDTH(8), .TIMEOUT(63)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .read_fifo_n (read_fifo_n),
    .tx_busy     (tx_busy),
    .ld_tx_data  (ld_tx_data),
    .tx_data     (tx_data),
    .tx_channel  (tx_channel),
    .timeout_err (timeout_err)
  );

  task automatic do_reset();
    reset_n    = 1'b0;
    fifo_empty = 4'hF;
    tx_busy    = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Observes one transaction from strobe to the cycle after LOAD exit.
  // tx_busy is raised during the busy_after-th LOAD cycle (0 = never).
  task automatic run_txn(input int busy_after, input bit empty_after_grant,
                         output bit ok, output int ch, output logic [7:0] data,
                         output logic [3:0] strobe, output logic [3:0] strobe_next,
                         output int ld_n, output bit terr, output bit terr_next);
    int t;
    ok = 1'b1; ch = -1; data = '0; strobe = '1; strobe_next = '1;
    ld_n = 0; terr = 1'b0; terr_next = 1'b0;
    t = 0;
    while (read_fifo_n === 4'hF && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      ok = 1'b0;
      return;
    end
    strobe = read_fifo_n;
    ch     = int'(tx_channel);
    if (empty_after_grant) fifo_empty = 4'hF;
    @(negedge clk);
    strobe_next = read_fifo_n;
    t = 0;
    while (ld_tx_data !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (t >= 10) begin
      ok = 1'b0;
      return;
    end
    data = tx_data;
    while (ld_tx_data === 1'b1 && ld_n < 200) begin
      ld_n++;
      if (ld_n == busy_after) tx_busy = 1'b1;
      @(negedge clk);
    end
    terr    = timeout_err;
    tx_busy = 1'b0;
    @(negedge clk);
    terr_next = timeout_err;
  endtask

  // Runs one transaction and compares it with the head of the scoreboard.
  task automatic test_txn(input string name, input int busy_after, input bit empty_after_grant);
    bit ok; int ch; logic [7:0] data; logic [3:0] s, sn; int ld_n; bit terr, terr_n;
    exp_t e;
    logic [3:0] exp_s;
    e = sb.pop_front();
    run_txn(busy_after, empty_after_grant, ok, ch, data, s, sn, ld_n, terr, terr_n);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_timeout no transaction within cycle budget", name);
      return;
    end
    exp_s = 4'hF;
    exp_s[e.ch] = 1'b0;
    checks++;
    if (ch !== e.ch) begin failures++; $display("FAIL %s_channel got=%0d exp=%0d", name, ch, e.ch); end
    checks++;
    if (s !== exp_s) begin failures++; $display("FAIL %s_strobe got=%b exp=%b", name, s, exp_s); end
    checks++;
    if (sn !== 4'hF) begin failures++; $display("FAIL %s_strobe_len got=%b exp=1111", name, sn); end
    checks++;
    if (data !== e.data) begin failures++; $display("FAIL %s_data got=%h exp=%h", name, data, e.data); end
    checks++;
    if (ld_n !== e.ld_n) begin failures++; $display("FAIL %s_ld_cycles got=%0d exp=%0d", name, ld_n, e.ld_n); end
    checks++;
    if (terr !== e.terr) begin failures++; $display("FAIL %s_timeout_err got=%0b exp=%0b", name, terr, e.terr); end
    checks++;
    if (terr_n !== 1'b0) begin failures++; $display("FAIL %s_timeout_err_len got=%0b exp=0", name, terr_n); end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    fifo_empty = 4'hF;
    tx_busy    = 1'b0;
    dval       = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (2) @(negedge clk);
    checks++;
    if (read_fifo_n !== 4'hF) begin failures++; $display("FAIL rst_strobe got=%b exp=1111", read_fifo_n); end
    checks++;
    if (ld_tx_data !== 1'b0) begin failures++; $display("FAIL rst_ld got=%0b exp=0", ld_tx_data); end
    checks++;
    if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
    checks++;
    if (tx_channel !== 2'd0) begin failures++; $display("FAIL rst_channel got=%0d exp=0", tx_channel); end
    checks++;
    if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_timeout_err got=%0b exp=0", timeout_err); end
    reset_n = 1'b1;
  endtask

  task automatic test_idle_park();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (read_fifo_n !== 4'hF || ld_tx_data !== 1'b0) begin
        failures++;
        $display("FAIL park_cycle%0d got strobe=%b ld=%0b exp strobe=1111 ld=0", i, read_fifo_n, ld_tx_data);
      end
    end
  endtask

  task automatic test_single();
    dval[2] = 8'hA5;
    sb.push_back('{ch: 2, data: 8'hA5, ld_n: 3, terr: 1'b0});
    fifo_empty = 4'b1011;
    test_txn("single", 3, 1'b0);
    fifo_empty = 4'hF;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_data !== 8'hA5) begin failures++; $display("FAIL single_hold got=%h exp=a5", tx_data); end
    checks++;
    if (tx_channel !== 2'd2) begin failures++; $display("FAIL single_ch_hold got=%0d exp=2", tx_channel); end
  endtask

  task automatic test_round_robin();
    int order [6];
    order = '{0, 1, 2, 3, 0, 1};
    do_reset();
    dval = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 6; i++)
      sb.push_back('{ch: order[i], data: dval[order[i]], ld_n: 2, terr: 1'b0});
    fifo_empty = 4'h0;
    for (int i = 0; i < 6; i++) test_txn($sformatf("rr%0d", i), 2, 1'b0);
    fifo_empty = 4'hF;
  endtask

  task automatic test_timeout();
    do_reset();
    dval = '{8'h11, 8'h22, 8'h33, 8'h44};
    sb.push_back('{ch: 1, data: 8'h22, ld_n: 64, terr: 1'b1});
    fifo_empty = 4'b1101;
    test_txn("tmo", 0, 1'b0);
    sb.push_back('{ch: 2, data: 8'h33, ld_n: 1, terr: 1'b0});
    fifo_empty = 4'b1000;
    test_txn("tmo_next", 1, 1'b0);
    fifo_empty = 4'hF;
  endtask

  task automatic test_empty_after_grant();
    do_reset();
    dval[0] = 8'h5C;
    sb.push_back('{ch: 0, data: 8'h5C, ld_n: 2, terr: 1'b0});
    fifo_empty = 4'b1110;
    test_txn("late_empty", 2, 1'b1);
    fifo_empty = 4'hF;
  endtask

  task automatic test_reset_in_load();
    int t;
    do_reset();
    dval = '{8'h11, 8'h22, 8'h33, 8'h44};
    sb.push_back('{ch: 1, data: 8'h22, ld_n: 2, terr: 1'b0});
    fifo_empty = 4'b1101;
    test_txn("pre_rst", 2, 1'b0);
    fifo_empty = 4'b0111;
    t = 0;
    while (ld_tx_data !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 50 || tx_channel !== 2'd3) begin
      failures++;
      $display("FAIL rst_load_reach got ch=%0d waited=%0d exp ch=3 in LOAD", tx_channel, t);
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ld_tx_data !== 1'b0) begin failures++; $display("FAIL async_rst_ld got=%0b exp=0", ld_tx_data); end
    checks++;
    if (tx_channel !== 2'd0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL async_rst_regs got ch=%0d data=%h exp ch=0 data=00", tx_channel, tx_data);
    end
    fifo_empty = 4'b1010;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (read_fifo_n !== 4'hF || ld_tx_data !== 1'b0) begin
      failures++;
      $display("FAIL rst_hold got strobe=%b ld=%0b exp strobe=1111 ld=0", read_fifo_n, ld_tx_data);
    end
    reset_n = 1'b1;
    sb.push_back('{ch: 0, data: 8'h11, ld_n: 2, terr: 1'b0});
    test_txn("post_rst", 2, 1'b0);
    fifo_empty = 4'hF;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle_park();
    test_single();
    test_round_robin();
    test_timeout();
    test_empty_after_grant();
    test_reset_in_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
